// File: rtl/fifo_pkt_pkg.sv
// Shared types and widths for the length-framed FIFO packet reader.
// Packets are one length byte followed by that many payload bytes.
package fifo_pkt_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;

  typedef enum logic [0:0] {
    ST_HDR     = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  // True when the remaining-byte count marks the final payload beat.
  function automatic logic rem_is_last(input logic [LEN_W-1:0] rem);
    return (rem == LEN_W'(1));
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular buffer that catches registered FIFO read data so that
// downstream stalls never drop a byte already requested from the FIFO.
module fifo_skid_buf #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  // Guarded push/pop and next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    do_pop   = pop && (occ_q != OCC_W'(0));
    do_push  = push && ((occ_q < OCC_W'(DEPTH)) || do_pop);
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      occ_q    <= OCC_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Pops length-framed packets from an 8-bit FIFO and emits payload bytes on a
// valid/ready stream with out_last on each packet's final byte.
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int SKID_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              err_zero_len,
  output logic              busy
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               inflight_q, inflight_d;
  logic               pop;
  logic [DATA_W-1:0]  head;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W:0]     pending;
  logic               head_avail;

  fifo_skid_buf #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  // Reads are issued only from registered occupancy so out_ready never
  // reaches fifo_rd_en combinationally; every request has a reserved slot.
  always_comb begin
    pending    = {1'b0, occ} + (OCC_W + 1)'(inflight_q);
    fifo_rd_en = !rst && !fifo_empty && (pending < (OCC_W + 1)'(SKID_DEPTH));
    inflight_d = fifo_rd_en;
  end

  // Header/payload sequencing on the skid head.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    head_avail = (occ != OCC_W'(0));
    case (state_q)
      ST_HDR: begin
        if (head_avail) begin
          pop   = 1'b1;
          rem_d = head;
          if (head == LEN_W'(0)) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          pop = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        out_valid = head_avail;
        out_last  = head_avail && rem_is_last(rem_q);
        if (out_valid && out_ready) begin
          pop   = 1'b1;
          rem_d = rem_q - LEN_W'(1);
          if (rem_is_last(rem_q)) begin
            state_d = ST_HDR;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          pop = 1'b0;
        end
      end
      default: begin
        state_d = ST_HDR;
        rem_d   = LEN_W'(0);
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HDR;
      rem_q      <= LEN_W'(0);
      cnt_q      <= CNT_W'(0);
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
    end
  end

  assign out_data     = head;
  assign pkt_count    = cnt_q;
  assign err_zero_len = err_q;
  assign busy         = (state_q == ST_PAYLOAD) || (occ != OCC_W'(0)) || inflight_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Scoreboard bench for fifo_pkt_reader: a queue-backed FIFO model feeds the
// DUT, directed tests push expected beats, and a monitor pops and compares.
module tb_fifo_pkt_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] pkt_count;
  logic        err_zero_len;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] fq [$];
  logic [8:0] exp_q [$];
  int  cyc        = 0;
  int  beats      = 0;
  int  err_pulses = 0;
  int  stalls     = 0;
  int  first_rd   = -1;
  int  first_val  = -1;
  int  last_beat  = -1;
  int  max_occ    = 0;
  bit  toggle_mode = 1'b0;
  bit  prev_stall  = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  fifo_pkt_reader #(.SKID_DEPTH(3), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .pkt_count    (pkt_count),
    .err_zero_len (err_zero_len),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // FIFO model: registered read data, one cycle after an accepted pop.
  initial begin
    fifo_rd_data = 8'h00;
    forever begin
      @(posedge clk);
      if (fifo_rd_en && !fifo_empty && fq.size() > 0) fifo_rd_data <= fq.pop_front();
    end
  end

  // Empty flag refreshed just after each edge so it is stable at negedge.
  initial begin
    fifo_empty = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      fifo_empty = (fq.size() == 0);
    end
  end

  // Ready driver: held high, or 1,0,0 repeating in toggle mode.
  initial begin
    int ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) begin
        out_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
        if (err_zero_len) err_pulses++;
        if (fifo_rd_en && first_rd < 0) first_rd = cyc;
        if (out_valid && first_val < 0) first_val = cyc;
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
          check("hold_last", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %0h last %0b, expected no beat", out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e[7:0]);
            check("beat_last", out_last, e[8]);
          end
          beats++;
          last_beat = cyc;
        end
        if (out_valid && !out_ready) stalls++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  task automatic load(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic expb(input logic [7:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    beats = 0; err_pulses = 0; stalls = 0;
    first_rd = -1; first_val = -1; last_beat = -1; max_occ = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d beats pending, expected 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_beats(input int target, input string name);
    int n = 0;
    while (beats < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_beats_timeout: got %0d beats, expected %0d", name, beats, target);
    end
  endtask

  initial begin
    int gap_valid;
    int gap_busy;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err_zero_len, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_pkt_count", pkt_count, 0);

    // Single 3-byte packet.
    load(8'h03); load(8'hAA); load(8'hBB); load(8'hCC);
    expb(8'hAA, 1'b0); expb(8'hBB, 1'b0); expb(8'hCC, 1'b1);
    wait_idle("t1");
    check("t1_pkt_count", pkt_count, 1);
    check("t1_latency", first_val - first_rd, 3);
    check("t1_err", err_pulses, 0);

    // Back-to-back packets.
    do_reset();
    load(8'h02); load(8'h11); load(8'h22); load(8'h01); load(8'h33);
    expb(8'h11, 1'b0); expb(8'h22, 1'b1); expb(8'h33, 1'b1);
    wait_idle("t2");
    check("t2_pkt_count", pkt_count, 2);
    check("t2_span", last_beat - first_val, 3);

    // Back-pressure with ready 1,0,0 repeating.
    do_reset();
    toggle_mode = 1'b1;
    load(8'h04); load(8'h01); load(8'h02); load(8'h03); load(8'h04);
    expb(8'h01, 1'b0); expb(8'h02, 1'b0); expb(8'h03, 1'b0); expb(8'h04, 1'b1);
    wait_idle("t3");
    toggle_mode = 1'b0;
    check("t3_pkt_count", pkt_count, 1);
    check("t3_occ_le3", int'(max_occ <= 3), 1);
    check("t3_stalled", int'(stalls > 0), 1);

    // Zero-length header.
    do_reset();
    load(8'h00); load(8'h01); load(8'h5A);
    expb(8'h5A, 1'b1);
    wait_idle("t4");
    check("t4_err_pulses", err_pulses, 1);
    check("t4_pkt_count", pkt_count, 1);

    // FIFO runs dry mid-packet.
    do_reset();
    load(8'h05); load(8'hB1); load(8'hB2);
    expb(8'hB1, 1'b0); expb(8'hB2, 1'b0); expb(8'hB3, 1'b0);
    expb(8'hB4, 1'b0); expb(8'hB5, 1'b1);
    wait_beats(2, "t5");
    gap_valid = 0;
    gap_busy  = 1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) gap_valid++;
      if (!busy) gap_busy = 0;
    end
    check("t5_gap_valid", gap_valid, 0);
    check("t5_gap_busy", gap_busy, 1);
    load(8'hB3); load(8'hB4); load(8'hB5);
    wait_idle("t5");
    check("t5_beats", beats, 5);
    check("t5_pkt_count", pkt_count, 1);

    // Reset mid-packet, then a fresh packet.
    do_reset();
    load(8'h04); load(8'hC1); load(8'hC2); load(8'hC3); load(8'hC4);
    expb(8'hC1, 1'b0); expb(8'hC2, 1'b0);
    wait_beats(2, "t6");
    do_reset();
    @(negedge clk);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_last", out_last, 0);
    check("t6_busy", busy, 0);
    check("t6_err", err_zero_len, 0);
    check("t6_rd_en", fifo_rd_en, 0);
    check("t6_pkt_count", pkt_count, 0);
    load(8'h01); load(8'h77);
    expb(8'h77, 1'b1);
    wait_idle("t6b");
    check("t6_pkt_after", pkt_count, 1);
    check("t6_beats_after", beats, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
- Drains the team's 8-bit synchronous FIFO from its read side and presents a length-framed packet stream on a valid/ready output.
- The FIFO carries packets as one header byte (payload length N) followed by N payload bytes. This block strips the header and emits payload beats with out_last on the final one.
- Sits directly between the FIFO's read port and any downstream byte consumer. It absorbs the FIFO's one-cycle registered read latency with a small skid buffer, so downstream back-pressure never loses data.

Parameters:
- SKID_DEPTH, 3, skid buffer entries; minimum 3, which gives full throughput with no combinational path from out_ready to fifo_rd_en.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_rd_en  out  1  pop request to the FIFO.
- fifo_rd_data  in  8  FIFO read data, valid the cycle after fifo_rd_en was high with fifo_empty low.
- fifo_empty  in  1  FIFO empty flag.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  this beat is the last payload byte of the packet.
- pkt_count  out  CNT_W  number of completed packets; wraps modulo 2^CNT_W.
- err_zero_len  out  1  one-cycle pulse when a header with N=0 is consumed.
- busy  out  1  high while in PAYLOAD state or while the skid buffer or an in-flight read is non-empty.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Skid buffer emptied; in-flight flag cleared; FSM set to HDR; remaining counter 0; pkt_count 0.
  - Outputs low: fifo_rd_en, out_valid, out_last, err_zero_len, busy.
  - fifo_rd_en is forced 0 while rst is high.
  - FIFO data returning in the cycle after reset is discarded.
  - Reset mid-packet drops the partial packet with no out_last.
- Read issue:
  - fifo_rd_en = !rst && !fifo_empty && (occ + inflight) < SKID_DEPTH.
  - occ and inflight are register values; the term does not depend on out_ready.
  - inflight <= fifo_rd_en.
  - When inflight=1, fifo_rd_data is written to the skid tail in that cycle.
- Skid buffer:
  - Circular, SKID_DEPTH x 8.
  - Same-cycle push and pop are allowed; occ is unchanged when both occur.
  - Overflow is impossible by construction; the bench asserts occ <= SKID_DEPTH.
- FSM, operating on the skid head; the head is "available" when occ>0:
  - HDR: out_valid=0. On head available, pop it internally and load rem <= head.
    - head==0: stay in HDR and pulse err_zero_len the next cycle.
    - head!=0: go to PAYLOAD.
  - PAYLOAD:
    - Outputs: out_valid = (occ>0); out_data = head; out_last = out_valid && rem==1.
    - Handshake when out_valid && out_ready: pop the head and decrement rem.
    - If rem was 1, go to HDR and increment pkt_count.
- Throughput and latency:
  - Header consumption costs one cycle per packet.
  - Steady-state payload throughput is 1 beat/cycle with out_ready held high.
  - From the first fifo_rd_en of a header, the first payload out_valid appears 3 cycles later: header arrives in +1, is consumed in +2, payload head is valid in +3.
- Back-pressure: out_data/out_last hold stable while out_valid && !out_ready; no beat is dropped or duplicated.
- FIFO goes empty mid-packet: out_valid drops when occ=0, rem is retained, and the packet resumes when data returns.
- Arithmetic: rem is 8-bit; N=255 is the largest legal packet; no wrap occurs within rem.

Decomposition:
- Shared package fifo_pkt_pkg:
  - FSM state typedef {ST_HDR, ST_PAYLOAD}.
  - Localparams DATA_W=8 and LEN_W=8.
- One sub-module: fifo_skid_buf (parameterised depth and width).
  - Inputs: push, push_data, pop.
  - Outputs: head, occ.
- The FSM and read-issue logic live in the top module.

Test Plan:
- Reset then FIFO holds 03 AA BB CC, out_ready=1 → out beats AA, BB, CC; out_last on CC only; pkt_count=1; first out_valid 3 cycles after first fifo_rd_en.
- Back-to-back packets 02 11 22 01 33 with out_ready=1 → beats 11, 22(last), 33(last); pkt_count=2; payload throughput 1 beat/cycle except one header cycle.
- Packet 04 01 02 03 04 with out_ready toggling 1,0,0,1,… → data held stable while stalled; occ never exceeds 3; all four bytes delivered in order, last on 04.
- Zero-length header 00 followed by 01 5A → err_zero_len pulses once; output 5A(last); pkt_count=1.
- Packet 05 plus 2 payload bytes, then fifo_empty for 10 cycles, then 3 bytes → out_valid low during the gap; rem preserved; five beats total, last on fifth.
- rst asserted for 1 cycle after 2 of 4 payload bytes sent → all outputs 0 the cycle after; pkt_count=0; the next packet 01 77 emits 77(last) correctly.
